// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: drives PLL reset, supervises LOCK and releases the downstream reset after stable lock
// Ports: CLKI reference clock, RST async active-high reset, LOCK async PLL lock input;
// PLL_RST/SYS_RST resets to the PLL and the downstream design, READY high in RUN, FAIL high in FAIL,
// RETRY_CNT lock timeouts since the last good lock, STATE current state encoding.
module pll_lock_sequencer #(
  parameter int RST_PULSE_CYC    = 16,
  parameter int LOCK_TIMEOUT_CYC = 90000,
  parameter int LOCK_STABLE_CYC  = 256,
  parameter int MAX_RETRY        = 5
) (
  input  logic       CLKI,
  input  logic       RST,
  input  logic       LOCK,
  output logic       PLL_RST,
  output logic       SYS_RST,
  output logic       READY,
  output logic       FAIL,
  output logic [2:0] RETRY_CNT,
  output logic [2:0] STATE
);
  localparam int MAX_A = RST_PULSE_CYC > LOCK_TIMEOUT_CYC ? RST_PULSE_CYC : LOCK_TIMEOUT_CYC;
  localparam int MAX_C = MAX_A > LOCK_STABLE_CYC ? MAX_A : LOCK_STABLE_CYC;
  localparam int CW = $clog2(MAX_C);
  localparam logic [CW-1:0] RST_END = CW'(RST_PULSE_CYC - 1);
  localparam logic [CW-1:0] TO_END  = CW'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] ST_END  = CW'(LOCK_STABLE_CYC - 1);
  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_WAIT   = 3'd1,
    S_STABLE = 3'd2,
    S_RUN    = 3'd3,
    S_FAIL   = 3'd4
  } state_t;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    retry_q, retry_d;
  logic          lock_m_q, lock_m_d, lock_s_q, lock_s_d;
  logic          pll_rst_q, pll_rst_d, sys_rst_q, sys_rst_d, ready_q, ready_d, fail_q, fail_d;
  always_comb begin
    lock_m_d = LOCK;
    lock_s_d = lock_m_q;
    state_d  = state_q;
    retry_d  = retry_q;
    case (state_q)
      S_RESET:  if (cnt_q == RST_END) state_d = S_WAIT;
      // lock has priority over a timeout landing on the same cycle
      S_WAIT:   if (lock_s_q) state_d = S_STABLE;
                else if (cnt_q == TO_END) begin
                  if (retry_q == 3'(MAX_RETRY)) state_d = S_FAIL;
                  else begin
                    state_d = S_RESET;
                    retry_d = retry_q + 3'd1;
                  end
                end
      S_STABLE: if (!lock_s_q) state_d = S_WAIT;
                else if (cnt_q == ST_END) begin
                  state_d = S_RUN;
                  retry_d = 3'd0;
                end
      S_RUN:    if (!lock_s_q) state_d = S_RESET;
      S_FAIL:   state_d = S_FAIL;
      default:  state_d = S_RESET;
    endcase
    // one shared counter restarts on every state change; it idles in RUN and FAIL
    cnt_d = state_d != state_q ? '0 :
            state_q inside {S_RESET, S_WAIT, S_STABLE} ? cnt_q + CW'(1) : cnt_q;
    // outputs decode the next state so they move on the same edge as STATE
    pll_rst_d = state_d == S_RESET || state_d == S_FAIL;
    sys_rst_d = state_d != S_RUN;
    ready_d   = state_d == S_RUN;
    fail_d    = state_d == S_FAIL;
  end
  always_ff @(posedge CLKI or posedge RST) begin
    if (RST) begin
      lock_m_q  <= 1'b0;
      lock_s_q  <= 1'b0;
      state_q   <= S_RESET;
      cnt_q     <= '0;
      retry_q   <= 3'd0;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      lock_m_q  <= lock_m_d;
      lock_s_q  <= lock_s_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      pll_rst_q <= pll_rst_d;
      sys_rst_q <= sys_rst_d;
      ready_q   <= ready_d;
      fail_q    <= fail_d;
    end
  end
  assign PLL_RST   = pll_rst_q;
  assign SYS_RST   = sys_rst_q;
  assign READY     = ready_q;
  assign FAIL      = fail_q;
  assign RETRY_CNT = retry_q;
  assign STATE     = state_q;
endmodule
